// File: rtl/uart_pkg.sv
// Shared constants for the serial datapath blocks.
// The FIFO takes its default geometry from here.
package uart_pkg;

  localparam int FIFO_DLEN = 8;
  localparam int FIFO_ALEN = 4;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port and one registered read port with enable.
// The array itself is never reset; only the read register is.
module fifo_ram
  import uart_pkg::*;
#(
  parameter int DLEN = FIFO_DLEN,
  parameter int ALEN = FIFO_ALEN
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            we,
  input  logic [ALEN-1:0] waddr,
  input  logic [DLEN-1:0] wdata,
  input  logic            re,
  input  logic [ALEN-1:0] raddr,
  output logic [DLEN-1:0] rdata
);

  localparam int DEPTH = 1 << ALEN;

  logic [DLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read-before-write: a same-address write is resolved by the caller's bypass.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO with registered count and write-to-read bypass.
// Handshake: a word moves only in a cycle where its valid and ready are both high at the rising edge.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DLEN = FIFO_DLEN,
  parameter int ALEN = FIFO_ALEN
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_clear,
  input  logic            i_wvalid,
  input  logic [DLEN-1:0] i_wdata,
  output logic            o_wready,
  output logic            o_rvalid,
  output logic [DLEN-1:0] o_rdata,
  input  logic            i_rready,
  output logic [ALEN:0]   o_count,
  output logic            o_full,
  output logic            o_empty
);

  localparam logic [ALEN:0] FULL_CNT = {1'b1, {ALEN{1'b0}}};

  logic [ALEN-1:0] wptr;
  logic [ALEN-1:0] rptr;
  logic [ALEN-1:0] raddr;
  logic [DLEN-1:0] ram_rdata;
  logic            push;
  logic            pop;
  logic            byp_sel;
  logic [DLEN-1:0] byp_data;

  assign o_full   = (o_count == FULL_CNT);
  assign o_empty  = (o_count == '0);
  assign o_wready = !o_full;
  assign o_rvalid = !o_empty;

  assign push = i_wvalid && o_wready;
  assign pop  = o_rvalid && i_rready;

  // Look one entry ahead on a pop so the new head is on o_rdata the next cycle.
  assign raddr = pop ? rptr + ALEN'(1) : rptr;

  always_ff @(posedge clk) begin
    if (!rstn || i_clear) begin
      wptr    <= '0;
      rptr    <= '0;
      o_count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + ALEN'(1);
      end
      if (pop) begin
        rptr <= rptr + ALEN'(1);
      end
      if (push && !pop) begin
        o_count <= o_count + (ALEN+1)'(1);
      end else if (pop && !push) begin
        o_count <= o_count - (ALEN+1)'(1);
      end
    end
  end

  // The RAM returns the old word when written and read at one address; forward the new one.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      byp_sel  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_sel  <= push && (wptr == raddr);
      byp_data <= i_wdata;
    end
  end

  assign o_rdata = byp_sel ? byp_data : ram_rdata;

  fifo_ram #(
    .DLEN(DLEN),
    .ALEN(ALEN)
  ) u_ram (
    .clk  (clk),
    .rstn (rstn),
    .we   (push),
    .waddr(wptr),
    .wdata(i_wdata),
    .re   (1'b1),
    .raddr(raddr),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed scenarios plus random traffic against a queue model.
module tb_sync_fifo;

  localparam int DLEN  = 8;
  localparam int ALEN  = 4;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            i_clear = 1'b0;
  logic            i_wvalid = 1'b0;
  logic [DLEN-1:0] i_wdata = '0;
  logic            i_rready = 1'b0;
  logic            o_wready;
  logic            o_rvalid;
  logic [DLEN-1:0] o_rdata;
  logic [ALEN:0]   o_count;
  logic            o_full;
  logic            o_empty;

  logic [DLEN-1:0] exp_q[$];
  int              n_checks = 0;
  int              n_errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  sync_fifo #(
    .DLEN(DLEN),
    .ALEN(ALEN)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_clear (i_clear),
    .i_wvalid(i_wvalid),
    .i_wdata (i_wdata),
    .o_wready(o_wready),
    .o_rvalid(o_rvalid),
    .o_rdata (o_rdata),
    .i_rready(i_rready),
    .o_count (o_count),
    .o_full  (o_full),
    .o_empty (o_empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every visible output against the model queue.
  task automatic check_status(input logic in_rst);
    int n;
    n = exp_q.size();
    check("count",  32'(o_count),  32'(n));
    check("empty",  32'(o_empty),  32'(n == 0));
    check("full",   32'(o_full),   32'(n == DEPTH));
    check("wready", 32'(o_wready), 32'(n != DEPTH));
    check("rvalid", 32'(o_rvalid), 32'(n != 0));
    if (in_rst) begin
      check("rst_rdata", 32'(o_rdata), 32'(0));
    end else if (n != 0) begin
      check("rdata", 32'(o_rdata), 32'(exp_q[0]));
    end
  endtask

  // driver: one clock cycle with the given inputs; model advances, outputs checked #1 after the edge
  task automatic cycle(input logic rst, input logic cl, input logic wv,
                       input logic [DLEN-1:0] wd, input logic rr);
    bit do_push;
    bit do_pop;
    rstn     = !rst;
    i_clear  = cl;
    i_wvalid = wv;
    i_wdata  = wd;
    i_rready = rr;
    do_push  = wv && (exp_q.size() < DEPTH);
    do_pop   = rr && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    if (rst || cl) begin
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(wd);
    end
    check_status(rst);
  endtask

  initial begin
    // reset, then idle
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("idle_empty", 32'(o_empty), 32'(1));
    check("idle_wready", 32'(o_wready), 32'(1));

    // single word fall-through
    cycle(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
    check("a5_rvalid", 32'(o_rvalid), 32'(1));
    check("a5_rdata", 32'(o_rdata), 32'hA5);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("a5_popped_empty", 32'(o_empty), 32'(1));

    // fill to full, refused 17th push, ordered drain
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, 8'(i), 1'b0);
    check("fill_full", 32'(o_full), 32'(1));
    check("fill_count", 32'(o_count), 32'(16));
    cycle(1'b0, 1'b0, 1'b1, 8'hEE, 1'b0);
    check("push17_count", 32'(o_count), 32'(16));
    check("push17_wready", 32'(o_wready), 32'(0));
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", 32'(o_rdata), 32'(i));
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    end
    check("drain_empty", 32'(o_empty), 32'(1));

    // count=1 streaming across pointer wrap
    cycle(1'b0, 1'b0, 1'b1, 8'h40, 1'b0);
    for (int i = 0; i < 40; i++) begin
      check("stream_head", 32'(o_rdata), 32'(8'h40 + 8'(i)));
      cycle(1'b0, 1'b0, 1'b1, 8'h41 + 8'(i), 1'b1);
      check("stream_count", 32'(o_count), 32'(1));
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // clear wins over a same-cycle push
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'h10 + 8'(i), 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
    check("clear_count", 32'(o_count), 32'(0));
    check("clear_empty", 32'(o_empty), 32'(1));
    cycle(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
    check("after_clear_rdata", 32'(o_rdata), 32'h3C);
    check("after_clear_rvalid", 32'(o_rvalid), 32'(1));
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // random traffic with rare clears and one reset mid-stream
    for (int i = 0; i < 2000; i++) begin
      cycle((i == 1000) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            8'($urandom),
            1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
